demux_buf: RTL and testbench
============================

Name: demux_buf

Overview:
- Registered 1-to-2 stream demultiplexer with valid/ready handshakes. It is the inverse of the datapath 2:1 select.
- One 32-bit input stream is steered to output 0 or output 1 by a per-word select bit.
- Each output has its own small FIFO, so a stalled consumer never blocks words bound for the other output once they are accepted.
- Sits after EX to steer results to the writeback path (out0) or the memory/MMIO path (out1).

Parameters:
- WIDTH, 32: data width in bits.
- DEPTH, 2: entries per output FIFO. Must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_sel  input  1  destination of the input word: 0 to out0, 1 to out1.
- in_data  input  WIDTH  input word.
- in_ready  output  1  input word accepted this cycle if in_valid is also high.
- out0_valid  output  1  out0 FIFO non-empty.
- out0_data  output  WIDTH  head of the out0 FIFO.
- out0_ready  input  1  consumer takes out0 this cycle.
- out1_valid  output  1  out1 FIFO non-empty.
- out1_data  output  WIDTH  head of the out1 FIFO.
- out1_ready  input  1  consumer takes out1 this cycle.
- cnt0  output  log2(DEPTH)+1  current occupancy of the out0 FIFO.
- cnt1  output  log2(DEPTH)+1  current occupancy of the out1 FIFO.

Behaviour:
- Reset, synchronous, rst=1 at a rising edge:
  - Both FIFOs empty, pointers 0, storage cleared to 0.
  - out0_valid=out1_valid=0, out0_data=out1_data=0, cnt0=cnt1=0.
  - in_ready=0 while rst is high.
  - Reset during traffic discards all buffered words. No partial transfer survives.
- Input handshake:
  - in_ready = !rst && !full[in_sel]. This is the only combinational path, in_sel to in_ready.
  - in_ready never depends on out*_ready, so a pop and a push in the same cycle on a full FIFO do not admit the push.
  - A push occurs when in_valid && in_ready. The word is written to the tail of FIFO[in_sel] and that tail pointer advances.
  - The other FIFO is untouched.
- Output handshake, per channel k:
  - outk_valid = (cntk != 0).
  - outk_data = storage[head_k], driven from registers.
  - A pop occurs when outk_valid && outk_ready, and head_k advances.
  - Asserting outk_ready while empty has no effect.
- Latency:
  - A word pushed at edge N is visible on outk_valid/outk_data after edge N, i.e. 1 cycle.
  - No combinational in-to-out bypass.
- Occupancy update per channel, each edge:
  - push only: cnt+1.
  - pop only: cnt-1.
  - push and pop together: cnt unchanged, and the FIFO must be non-empty for the pop.
  - A push into an empty FIFO cannot pop in the same cycle, because outk_valid was 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = (cnt == DEPTH), empty = (cnt == 0).
- Ordering:
  - Per channel, strict FIFO order.
  - No ordering guarantee between channels.
- Independence: out0 stalled and full never affects acceptance or draining of words with in_sel=1, and vice versa.
- Input stalls:
  - If in_valid is held with in_ready=0, the upstream holds in_data/in_sel stable. The block does not rely on this for correctness.
  - The block does not latch unaccepted words.
- X-safety: in_data is written to storage only on a push, and in_sel is ignored when in_valid=0.

Decomposition:
- Shared package: WIDTH default, the select encodings SEL_WB=0 and SEL_MEM=1, and the clog2-based pointer/count width function.
- One natural sub-module: sync_fifo, parameterised by WIDTH/DEPTH, with push/pop/full/empty/count and synchronous active-high rst.
- demux_buf instantiates sync_fifo twice and adds the select and in_ready logic.

Test Plan:
- Reset values: hold rst=1 for 3 cycles with in_valid=1 -> in_ready=0, both outk_valid=0, outk_data=0, cnt0=cnt1=0; no pushes.
- Basic routing, out*_ready=1: push 0xAAAA0001 sel0, 0xBBBB0002 sel1, 0xAAAA0003 sel0 on consecutive cycles -> out0 emits 0xAAAA0001 then 0xAAAA0003, out1 emits 0xBBBB0002, each 1 cycle after its push.
- Full and independence, DEPTH=2, out0_ready=0:
  - Push sel0 0x10, 0x11 -> cnt0=2.
  - Third sel0 word -> in_ready=0, stays blocked.
  - Change to sel1 0x20 -> in_ready=1, out1 emits 0x20.
- Full with simultaneous pop:
  - With out0 full, assert out0_ready=1 and in_valid sel0 0x12 -> no push that cycle, cnt0=1.
  - Next cycle push accepted -> out0 order 0x10, 0x11, 0x12.
- Wrap-around: stream 16 words 0x100..0x10F sel0 with out0_ready toggling 1,0 -> all 16 received in order, cnt0 never exceeds 2, pointers wrap cleanly.
- Reset mid-operation: with cnt0=2 and cnt1=1, assert rst for 1 cycle -> next cycle cnt0=cnt1=0, out*_valid=0, and earlier words never appear afterwards.

Source files
------------

// File: rtl/demux_buf_pkg.sv
// demux_buf_pkg: shared widths, select encodings and pointer/count sizing for demux_buf.
package demux_buf_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic SEL_WB = 1'b0;
  localparam logic SEL_MEM = 1'b1;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/demux_buf_sync_fifo.sv
// sync_fifo: registered-output synchronous FIFO with occupancy count.
module sync_fifo
  import demux_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[head];
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= din;
        tail <= tail + PW'(1);
      end
      if (do_pop) head <= head + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/demux_buf.sv
// demux_buf: steers one valid/ready stream into two independently buffered outputs.
module demux_buf
  import demux_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sel,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out0_valid,
  output logic [WIDTH-1:0]         out0_data,
  input  logic                     out0_ready,
  output logic                     out1_valid,
  output logic [WIDTH-1:0]         out1_data,
  input  logic                     out1_ready,
  output logic [cnt_w(DEPTH)-1:0]  cnt0,
  output logic [cnt_w(DEPTH)-1:0]  cnt1
);
  logic full0, full1, empty0, empty1, push0, push1;
  // Acceptance looks only at the target FIFO's fullness, never at a same-cycle pop.
  assign in_ready = !rst && (in_sel == SEL_MEM ? !full1 : !full0);
  assign push0 = in_valid && in_ready && in_sel == SEL_WB;
  assign push1 = in_valid && in_ready && in_sel == SEL_MEM;
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .push(push0), .pop(out0_ready), .din(in_data),
    .dout(out0_data), .full(full0), .empty(empty0), .count(cnt0)
  );
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push(push1), .pop(out1_ready), .din(in_data),
    .dout(out1_data), .full(full1), .empty(empty1), .count(cnt1)
  );
endmodule

// File: tb/tb_demux_buf.sv
// tb_demux_buf: queue-model checked directed and random traffic for demux_buf.
module tb_demux_buf;
  import demux_buf_pkg::*;
  localparam int W = 32;
  localparam int D = 2;
  localparam int CW = cnt_w(D);
  logic clk = 0, rst = 0, in_valid = 0, in_sel = 0, out0_ready = 0, out1_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out0_valid, out1_valid;
  logic [W-1:0] out0_data, out1_data;
  logic [CW-1:0] cnt0, cnt1;
  int total = 0, bad = 0, max0 = 0;
  logic [W-1:0] q0[$], q1[$], rec0[$], rec1[$], e[$];
  bit armed = 0, fresh0 = 0, fresh1 = 0, p0, p1, a;

  demux_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data),
    .in_ready(in_ready), .out0_valid(out0_valid), .out0_data(out0_data),
    .out0_ready(out0_ready), .out1_valid(out1_valid), .out1_data(out1_data),
    .out1_ready(out1_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkq(input string n, input logic [W-1:0] g[$], input logic [W-1:0] x[$]);
    chk({n, "_len"}, 64'(g.size()), 64'(x.size()));
    for (int i = 0; i < x.size() && i < g.size(); i++) chk(n, 64'(g[i]), 64'(x[i]));
  endtask

  // Model: queues hold the words each FIFO must contain after the last edge.
  always @(negedge clk) begin
    if (rst) chk("in_ready_rst", 64'(in_ready), 64'(0));
    if (armed) begin
      if (!rst) chk("in_ready", 64'(in_ready), 64'((in_sel ? q1.size() : q0.size()) < D));
      chk("out0_valid", 64'(out0_valid), 64'(q0.size() != 0));
      chk("out1_valid", 64'(out1_valid), 64'(q1.size() != 0));
      chk("cnt0", 64'(cnt0), 64'(q0.size()));
      chk("cnt1", 64'(cnt1), 64'(q1.size()));
      if (q0.size() != 0) chk("out0_data", 64'(out0_data), 64'(q0[0]));
      else if (fresh0) chk("out0_data_rst", 64'(out0_data), 64'(0));
      if (q1.size() != 0) chk("out1_data", 64'(out1_data), 64'(q1[0]));
      else if (fresh1) chk("out1_data_rst", 64'(out1_data), 64'(0));
      if (q0.size() > max0) max0 = q0.size();
    end
    if (rst) begin
      q0.delete();
      q1.delete();
      armed = 1;
      fresh0 = 1;
      fresh1 = 1;
    end else if (armed) begin
      p0 = in_valid && !in_sel && q0.size() < D;
      p1 = in_valid && in_sel && q1.size() < D;
      if (q0.size() != 0 && out0_ready) begin rec0.push_back(out0_data); void'(q0.pop_front()); end
      if (q1.size() != 0 && out1_ready) begin rec1.push_back(out1_data); void'(q1.pop_front()); end
      if (p0) begin q0.push_back(in_data); fresh0 = 0; end
      if (p1) begin q1.push_back(in_data); fresh1 = 0; end
    end
  end

  task automatic step(input logic r, input logic v, input logic s, input logic [W-1:0] d,
                      input logic r0, input logic r1, output bit acc);
    rst = r; in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
    #1 acc = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rec();
    rec0.delete();
    rec1.delete();
  endtask

  initial begin
    int i, k;
    repeat (3) step(1, 1, 0, 32'hDEAD0000, 1, 1, a);
    chk("rst_cnt0", 64'(cnt0), 64'(0));
    chk("rst_cnt1", 64'(cnt1), 64'(0));
    chk("rst_out0_data", 64'(out0_data), 64'(0));
    clear_rec();
    step(0, 1, 0, 32'hAAAA0001, 1, 1, a);
    chk("lat0_valid", 64'(out0_valid), 64'(1));
    chk("lat0_data", 64'(out0_data), 64'h0000_0000_AAAA_0001);
    step(0, 1, 1, 32'hBBBB0002, 1, 1, a);
    step(0, 1, 0, 32'hAAAA0003, 1, 1, a);
    repeat (3) step(0, 0, 0, '0, 1, 1, a);
    e = {32'hAAAA0001, 32'hAAAA0003};
    chkq("basic0", rec0, e);
    e = {32'hBBBB0002};
    chkq("basic1", rec1, e);
    clear_rec();
    step(0, 1, 0, 32'h10, 0, 0, a);
    step(0, 1, 0, 32'h11, 0, 0, a);
    chk("full_cnt0", 64'(cnt0), 64'(2));
    step(0, 1, 0, 32'h12, 0, 0, a);
    chk("blocked_ready", 64'(in_ready), 64'(0));
    chk("blocked_cnt0", 64'(cnt0), 64'(2));
    step(0, 1, 1, 32'h20, 0, 0, a);
    chk("indep_acc", 64'(a), 64'(1));
    chk("indep_out1", 64'(out1_data), 64'h20);
    step(0, 0, 0, '0, 0, 1, a);
    step(0, 1, 0, 32'h12, 1, 0, a);
    chk("popfull_acc", 64'(a), 64'(0));
    chk("popfull_cnt0", 64'(cnt0), 64'(1));
    step(0, 1, 0, 32'h12, 1, 0, a);
    chk("push_after_acc", 64'(a), 64'(1));
    repeat (3) step(0, 0, 0, '0, 1, 1, a);
    e = {32'h10, 32'h11, 32'h12};
    chkq("full0", rec0, e);
    e = {32'h20};
    chkq("full1", rec1, e);
    clear_rec();
    max0 = 0;
    i = 0;
    k = 0;
    while (i < 16 && k < 200) begin
      step(0, 1, 0, W'(32'h100 + i), k % 2 == 0, 0, a);
      if (a) i++;
      k++;
    end
    chk("wrap_sent", 64'(i), 64'(16));
    repeat (4) step(0, 0, 0, '0, 1, 1, a);
    chk("wrap_max_over2", 64'(max0 > 2), 64'(0));
    e.delete();
    for (int j = 0; j < 16; j++) e.push_back(W'(32'h100 + j));
    chkq("wrap0", rec0, e);
    clear_rec();
    step(0, 1, 0, 32'h50, 0, 0, a);
    step(0, 1, 0, 32'h51, 0, 0, a);
    step(0, 1, 1, 32'h60, 0, 0, a);
    chk("pre_rst_cnt0", 64'(cnt0), 64'(2));
    chk("pre_rst_cnt1", 64'(cnt1), 64'(1));
    step(1, 0, 0, '0, 0, 0, a);
    chk("mid_rst_cnt0", 64'(cnt0), 64'(0));
    chk("mid_rst_cnt1", 64'(cnt1), 64'(0));
    chk("mid_rst_v0", 64'(out0_valid), 64'(0));
    chk("mid_rst_v1", 64'(out1_valid), 64'(0));
    chk("mid_rst_d1", 64'(out1_data), 64'(0));
    repeat (4) step(0, 0, 0, '0, 1, 1, a);
    chk("mid_rst_rec0", 64'(rec0.size()), 64'(0));
    chk("mid_rst_rec1", 64'(rec1.size()), 64'(0));
    repeat (800)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           W'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), a);
    step(0, 0, 0, '0, 0, 0, a);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
